timer_peripheral: RTL

Memory-mapped timer/counter peripheral. It is the responder for the TIM window of the data-bus decoder (chip select asserted for 0xC000_0080 to 0xC000_00A7). It decodes register offsets, services read/write strobes with fixed latency, and runs a prescaled up-counter with auto-reload, compare match and a level interrupt. It sits on the CPU data bus next to RAM, the PID, ADC, H7S and PTL peripherals, and its rdata feeds read-mux input 3'b100.

---
 rtl/tim_pkg.sv | 33 +++
 rtl/timer_peripheral_if.sv | 19 +
 rtl/tim_prescaler.sv | 37 +++
 rtl/timer_peripheral.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/tim_pkg.sv
// Shared definitions for the TIM timer peripheral.
//   - Register byte offsets inside the TIM window.
//   - Bit positions of the CTRL and STATUS fields.
//   - ctrl_t, the packed view of the CTRL register.
//   - ctrl_to_word(), which zero-extends CTRL to a bus word.
package tim_pkg;

  localparam logic [7:0] TIM_CTRL   = 8'h00;
  localparam logic [7:0] TIM_STATUS = 8'h04;
  localparam logic [7:0] TIM_PSC    = 8'h08;
  localparam logic [7:0] TIM_CNT    = 8'h0C;
  localparam logic [7:0] TIM_ARR    = 8'h10;
  localparam logic [7:0] TIM_CMP    = 8'h14;
  localparam logic [7:0] TIM_PCNT   = 8'h18;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ARE_BIT     = 1;
  localparam int CTRL_IE_BIT      = 2;
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_OVF_BIT   = 1;

  // Member order puts EN at bit 0, ARE at bit 1 and IE at bit 2.
  typedef struct packed {
    logic ie;
    logic are;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {29'd0, c};
  endfunction

endpackage

// File: rtl/timer_peripheral_if.sv
// CPU data-bus slice seen by the TIM peripheral.
// Handshake: a transfer happens on a rising edge when cs is high. On that edge,
// write applies wdata and read captures the addressed register into rdata.
// rdata is valid from the next cycle and holds until the next read. There are
// no wait states and no ready signal. irq is a level output.
//   master : drives cs, read, write, addr and wdata; observes rdata and irq.
//   slave  : the peripheral side.
interface timer_peripheral_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output cs, read, write, addr, wdata, input rdata, irq);
  modport slave  (input cs, read, write, addr, wdata, output rdata, irq);
endinterface

// File: rtl/tim_prescaler.sv
// Prescaler for the TIM peripheral.
//   clk, reset : system clock and synchronous active-high reset.
//   en         : counting enable (CTRL.EN).
//   clr        : forces pcnt to 0. Used when software writes CNT or PSC.
//   psc        : terminal count. tick fires while pcnt == psc.
//   pcnt       : current prescaler count.
//   tick       : one-cycle pulse. The counter advances on the edge that ends it.
module tim_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] psc,
  output logic [15:0] pcnt,
  output logic        tick
);

  logic [15:0] pcnt_q, pcnt_d;

  assign pcnt = pcnt_q;
  assign tick = en && (pcnt_q == psc);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = 16'd0;
    end else if (en) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pcnt_q <= 16'd0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped timer/counter. It responds to the TIM window of the data bus.
//   clk, reset : system clock and synchronous active-high reset.
//   bus        : slave side of timer_peripheral_if.
//                Inputs are cs, read, write, addr and wdata.
//                Outputs are rdata (registered, 1-cycle read latency) and irq.
// Contains the register file, the auto-reload up-counter and the
// compare/overflow flags. Prescaling is handled by tim_prescaler.
module timer_peripheral
  import tim_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hC000_0080,
  parameter int          NUM_WORDS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_peripheral_if.slave    bus
);

  localparam logic [31:0] WIN_BYTES = 32'(NUM_WORDS * 4);

  ctrl_t       ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic        ovf_q, ovf_d;
  logic [15:0] psc_q, psc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] arr_q, arr_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] offset;
  logic [7:0]  reg_off;
  logic        wr_en, rd_en;
  logic        wr_ctrl, wr_status, wr_psc, wr_cnt, wr_arr, wr_cmp;
  logic        pre_clr, tick, tick_eff;
  logic        hw_match, hw_ovf;
  logic [15:0] pcnt;
  logic [31:0] rd_mux;

  // Offsets outside the window, including addresses below the base, are
  // mapped to 0xFF. 0xFF matches no register, so they read 0 and ignore writes.
  always_comb begin
    offset  = bus.addr - BASE_ADDR;
    reg_off = (offset < WIN_BYTES) ? {offset[7:2], 2'b00} : 8'hFF;
    wr_en   = bus.cs & bus.write;
    rd_en   = bus.cs & bus.read;

    wr_ctrl   = wr_en && (reg_off == TIM_CTRL);
    wr_status = wr_en && (reg_off == TIM_STATUS);
    wr_psc    = wr_en && (reg_off == TIM_PSC);
    wr_cnt    = wr_en && (reg_off == TIM_CNT);
    wr_arr    = wr_en && (reg_off == TIM_ARR);
    wr_cmp    = wr_en && (reg_off == TIM_CMP);
  end

  // A software write to CNT or PSC restarts the prescale period.
  // It also cancels any tick that would land on the same edge.
  assign pre_clr  = wr_cnt | wr_psc;
  assign tick_eff = tick & ~pre_clr;

  tim_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q.en),
    .clr   (pre_clr),
    .psc   (psc_q),
    .pcnt  (pcnt),
    .tick  (tick)
  );

  // Read mux. It uses pre-write values, so a read+write returns the old value.
  always_comb begin
    rd_mux = 32'd0;
    case (reg_off)
      TIM_CTRL:   rd_mux = ctrl_to_word(ctrl_q);
      TIM_STATUS: rd_mux = {30'd0, ovf_q, match_q};
      TIM_PSC:    rd_mux = {16'd0, psc_q};
      TIM_CNT:    rd_mux = cnt_q;
      TIM_ARR:    rd_mux = arr_q;
      TIM_CMP:    rd_mux = cmp_q;
      TIM_PCNT:   rd_mux = {16'd0, pcnt};
      default:    rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    psc_d    = psc_q;
    cnt_d    = cnt_q;
    arr_d    = arr_q;
    cmp_d    = cmp_q;
    rdata_d  = rdata_q;
    hw_match = 1'b0;
    hw_ovf   = 1'b0;

    // The counter wraps at ARR. It also wraps at all-ones, so a CNT written
    // above ARR runs to the top and wraps there.
    if (tick_eff) begin
      hw_match = (cnt_q == cmp_q);
      if ((cnt_q == arr_q) || (cnt_q == 32'hFFFF_FFFF)) begin
        cnt_d  = 32'd0;
        hw_ovf = 1'b1;
        if (!ctrl_q.are) ctrl_d.en = 1'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    // Software writes are applied after the counter update, so they take
    // priority over the one-shot EN clear and over a tick to CNT.
    if (wr_ctrl) ctrl_d = ctrl_t'(bus.wdata[2:0]);
    if (wr_psc)  psc_d  = bus.wdata[15:0];
    if (wr_cnt)  cnt_d  = bus.wdata;
    if (wr_arr)  arr_d  = bus.wdata;
    if (wr_cmp)  cmp_d  = bus.wdata;

    // W1C flags. A hardware set on the same edge keeps the flag set.
    match_d = (match_q & ~(wr_status & bus.wdata[STATUS_MATCH_BIT])) | hw_match;
    ovf_d   = (ovf_q   & ~(wr_status & bus.wdata[STATUS_OVF_BIT]))   | hw_ovf;

    if (rd_en) rdata_d = rd_mux;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      psc_q   <= 16'd0;
      cnt_q   <= 32'd0;
      arr_q   <= 32'hFFFF_FFFF;
      cmp_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      arr_q   <= arr_d;
      cmp_q   <= cmp_d;
      rdata_q <= rdata_d;
    end
  end

  // irq is computed from registered flags only.
  assign bus.rdata = rdata_q;
  assign bus.irq   = ctrl_q.ie & (match_q | ovf_q);

endmodule
